// File: rtl/bin_attr_lookup.sv
// bin_attr_lookup: two-level BIN attribute lookup (index ROM -> class ROM -> name).
// Pipelined, tagged, in-order, with a credit-controlled output FIFO.
// Optional build macro: LOOKUP_RANGE_CHECK_EN turns on the index range check,
// which forces a miss (and raises rsp_oob) for indices >= ENTRY_COUNT.
// ROM contents come from the INDEX_MIF / NAME_MIF init files and are never reset.
`timescale 1ns/1ps
module bin_attr_lookup #(
    parameter int ENTRY_COUNT = 2638,
    parameter int ADDR_W = 12,
    parameter int CLASS_COUNT = 2,
    parameter int CLASS_W = 1,
    parameter int NAME_W = 30,
    parameter logic [NAME_W-1:0] NOT_FOUND_NAME = 30'b011100111101110001010000000000,
    parameter int TAG_W = 4,
    parameter int FIFO_DEPTH = 4,
    parameter INDEX_MIF = "./bindb/card_type_indices.mif",
    parameter NAME_MIF = "./bindb/card_type.mif"
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_found,
    input  logic [ADDR_W-1:0] req_index,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NAME_W-1:0] rsp_name,
    output logic              rsp_found,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_oob
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [NAME_W-1:0] name;
        logic              found;
        logic [TAG_W-1:0]  tag;
        logic              oob;
    } rsp_t;

    (* ram_init_file = INDEX_MIF *) logic [CLASS_W-1:0] index_rom [0:ENTRY_COUNT-1];
    (* ram_init_file = NAME_MIF *)  logic [NAME_W-1:0]  name_rom  [0:CLASS_COUNT-1];

    logic               v1, v2;
    logic [CLASS_W-1:0] class_q;
    logic               found1, oob1, found2, oob2;
    logic [TAG_W-1:0]   tag1, tag2;
    logic [NAME_W-1:0]  name2;

    rsp_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_n;
    logic [SUM_W-1:0]   credit_n;
    logic               rdy_q, rdy_n;

    logic               accept, push, pop, wr_en;
    logic               s1_found, s1_oob;
    logic [ADDR_W-1:0]  rom_addr;
    rsp_t               push_word, head;

`ifdef LOOKUP_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] ENTRY_LIM = (ADDR_W + 1)'(ENTRY_COUNT);
    // Out-of-range indices read a harmless address and are reported as misses
    assign s1_oob   = ({1'b0, req_index} >= ENTRY_LIM);
    assign rom_addr = s1_oob ? '0 : req_index;
    assign s1_found = req_found & ~s1_oob;
`else
    assign s1_oob   = 1'b0;
    assign rom_addr = req_index;
    assign s1_found = req_found;
`endif

    assign accept    = req_valid & rdy_q;
    assign push      = v2;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    // A push into a full FIFO is only legal together with a pop of the same slot
    assign wr_en     = push & ((count != DEPTH_C) | pop);
    assign req_ready = rdy_q;

    assign push_word.name  = found2 ? name2 : NOT_FOUND_NAME;
    assign push_word.found = found2;
    assign push_word.tag   = tag2;
    assign push_word.oob   = oob2;

    assign head      = fifo_mem[rd_ptr];
    assign rsp_name  = rsp_valid ? head.name  : '0;
    assign rsp_found = rsp_valid ? head.found : 1'b0;
    assign rsp_tag   = rsp_valid ? head.tag   : '0;
    assign rsp_oob   = rsp_valid ? head.oob   : 1'b0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Next FIFO occupancy and next credit: ready is registered so it never
    // depends combinationally on req_valid or rsp_ready
    always_comb begin
        count_n = count;
        if (wr_en && !pop)
            count_n = count + 1'b1;
        else if (!wr_en && pop)
            count_n = count - 1'b1;
        credit_n = SUM_W'(count_n) + SUM_W'(accept) + SUM_W'(v1);
        rdy_n    = (credit_n < SUM_W'(FIFO_DEPTH));
    end

    // ROM read data and FIFO storage carry no reset (block-RAM friendly)
    always_ff @(posedge CLOCK_50) begin
        if (accept)
            class_q <= index_rom[rom_addr];
        if (v1)
            name2 <= name_rom[class_q];
        if (wr_en)
            fifo_mem[wr_ptr] <= push_word;
    end

    // Pipeline valids, sideband, FIFO pointers and credit state
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            found1 <= 1'b0;
            oob1   <= 1'b0;
            tag1   <= '0;
            found2 <= 1'b0;
            oob2   <= 1'b0;
            tag2   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                found1 <= s1_found;
                oob1   <= s1_oob;
                tag1   <= req_tag;
            end
            v2 <= v1;
            if (v1) begin
                found2 <= found1;
                oob2   <= oob1;
                tag2   <= tag1;
            end
            if (wr_en)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count_n;
            rdy_q <= rdy_n;
        end
    end

endmodule
